// File: rtl/mem1_ctrl.sv
// mem1_ctrl: MEM-stage controller for the RAM1 port with a memory-mapped status word
module mem1_ctrl #(
  parameter logic [15:0] STATUS_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [15:0] status_i,
  input  logic [15:0] mem1res_i,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        stall,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        ram_read
);
  typedef enum logic [1:0] {IDLE, ACCESS, STATUS, DONE} state_t;
  state_t state;
  logic   we_q;
  assign req_ready = state == IDLE;
  assign stall     = req_valid && !resp_valid;
  // ram_addr/ram_data double as the latched request address and write data
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_read   <= 1'b0;
      resp_rdata <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      ram_read   <= 1'b0;
      ram_data   <= '0;
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          if (!req_we && req_addr == STATUS_ADDR) state <= STATUS;
          else begin
            state    <= ACCESS;
            ram_addr <= {2'b00, req_addr};
            ram_read <= req_we;
            ram_data <= req_we ? req_wdata : 16'h0000;
          end
        end
        ACCESS: begin
          if (!we_q) resp_rdata <= mem1res_i;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        STATUS: begin
          resp_rdata <= status_i;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem1_ctrl.sv
// tb_mem1_ctrl: scoreboard bench for mem1_ctrl with a RAM1 model and a reference memory
module tb_mem1_ctrl;
  localparam logic [15:0] STATUS_ADDR = 16'hBF01;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0, status_i = '0, mem1res_i = '0;
  logic req_ready, resp_valid, stall, ram_read;
  logic [15:0] resp_rdata, ram_data;
  logic [17:0] ram_addr;

  mem1_ctrl #(.STATUS_ADDR(STATUS_ADDR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .status_i(status_i), .mem1res_i(mem1res_i), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_read(ram_read)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [17:0] addr; logic rd; logic [15:0] data;} acc_t;
  typedef struct {int cyc; logic [15:0] rdata;} rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  logic [15:0] ram [logic [17:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] last_rdata = '0;
  logic [17:0] last_addr = '0;
  int errors = 0, checks = 0, cyc = 0, prev_acc = -100;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM1 model: strobes act on the falling edge
  always @(negedge clk)
    if (ram_read) ram[ram_addr] = ram_data;
    else mem1res_i = ram.exists(ram_addr) ? ram[ram_addr] : 16'h0000;

  initial forever begin
    acc_t a;
    rsp_t r;
    @(posedge clk);
    #1;
    chk("stall", stall, req_valid && !resp_valid);
    if (acc_q.size() != 0 && acc_q[0].cyc == cyc) begin
      a = acc_q.pop_front();
      chk("access_addr", ram_addr, a.addr);
      chk("access_read", ram_read, a.rd);
      chk("access_data", ram_data, a.data);
    end else chk("quiet_ram", {ram_read, ram_data}, 17'h0);
    if (resp_valid) begin
      if (rsp_q.size() == 0) chk("spurious_resp", 1, 0);
      else begin
        r = rsp_q.pop_front();
        chk("resp_latency", cyc, r.cyc);
        chk("resp_rdata", resp_rdata, r.rdata);
      end
    end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
      r = rsp_q.pop_front();
      chk("missing_resp", 0, 1);
    end
  end

  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input bit keep, input bit b2b);
    bit rdy;
    int n = 0, acc;
    acc_t x;
    rsp_t r;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    rdy = req_ready;
    while (!rdy) begin
      @(posedge clk);
      @(negedge clk);
      rdy = req_ready;
      if (++n > 8) begin
        chk("accept_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    if (b2b) chk("b2b_spacing", acc - prev_acc, 3);
    prev_acc = acc;
    if (!we && a == STATUS_ADDR) begin
      x = '{acc, last_addr, 1'b0, 16'h0};
      r.rdata = status_i;
    end else begin
      x = '{acc, {2'b00, a}, we, we ? d : 16'h0};
      last_addr = {2'b00, a};
      if (we) begin
        ref_mem[a] = d;
        r.rdata = last_rdata;
      end else r.rdata = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    end
    r.cyc = acc + 1;
    last_rdata = r.rdata;
    acc_q.push_back(x);
    rsp_q.push_back(r);
    @(negedge clk);
    req_addr = 16'($urandom);
    req_wdata = 16'($urandom);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    bit keep, prev_keep;
    int sel;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ram_addr", ram_addr, 18'h0);
    chk("rst_ram_read", ram_read, 1'b0);
    chk("rst_ram_data", ram_data, 16'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 16'h0);
    chk("rst_ready", req_ready, 1'b1);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);
    @(negedge clk);
    do_req(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
    do_req(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1);
    do_req(1'b1, 16'h1234, 16'h5A5A, 1'b0, 1'b1);
    status_i = 16'h0003;
    do_req(1'b0, STATUS_ADDR, 16'h0000, 1'b1, 1'b1);
    do_req(1'b1, STATUS_ADDR, 16'h1111, 1'b1, 1'b1);
    do_req(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1);
    do_req(1'b0, STATUS_ADDR, 16'h0000, 1'b0, 1'b1);
    // reset lands while a write sits in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h7777; req_wdata = 16'hDEAD;
    chk("pre_rst_ready", req_ready, 1'b1);
    acc_q.push_back('{cyc + 1, 18'h07777, 1'b1, 16'hDEAD});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_ready", req_ready, 1'b1);
    chk("midop_ram_read", ram_read, 1'b0);
    chk("midop_resp_valid", resp_valid, 1'b0);
    chk("midop_ram_addr", ram_addr, 18'h0);
    rst = 1'b0;
    req_valid = 1'b0;
    last_rdata = '0;
    last_addr = '0;
    prev_acc = -100;
    repeat (3) begin
      @(negedge clk);
      chk("dropped_no_resp", resp_valid, 1'b0);
    end
    prev_keep = 1'b0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      a = sel < 8 ? 16'(sel) : (sel == 8 ? 16'h0010 : STATUS_ADDR);
      status_i = 16'($urandom);
      keep = 1'($urandom_range(0, 1));
      do_req(1'($urandom_range(0, 1)), a, 16'($urandom), keep, prev_keep);
      if (!keep) repeat ($urandom_range(1, 2)) @(negedge clk);
      prev_keep = keep;
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
